// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pkg
// Description : Shared types and constants for the logic unit pipeline:
//               3-bit opcode enum, FSM state type and opcode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_pkg;

    // Bitwise operation selector
    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_ANDNOT = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

    // Burst controller states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    // Raw opcode values for code that works with plain logic vectors
    localparam logic [2:0] C_OP_AND    = 3'd0;
    localparam logic [2:0] C_OP_OR     = 3'd1;
    localparam logic [2:0] C_OP_XOR    = 3'd2;
    localparam logic [2:0] C_OP_NAND   = 3'd3;
    localparam logic [2:0] C_OP_NOR    = 3'd4;
    localparam logic [2:0] C_OP_XNOR   = 3'd5;
    localparam logic [2:0] C_OP_ANDNOT = 3'd6;
    localparam logic [2:0] C_OP_PASS_A = 3'd7;

endpackage
`default_nettype wire

// File: rtl/logic_unit_pipe_logic_op.sv
`default_nettype none
// ============================================================================
// Module      : logic_op
// Description : Combinational bitwise function o_y = f(i_op, i_x, i_z).
// Ports       : i_op [2:0]     operation select (op_e)
//               i_x  [WIDTH]   first operand
//               i_z  [WIDTH]   second operand
//               o_y  [WIDTH]   result
// Revision    : 1.0 - initial release
// ============================================================================
module logic_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_z,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = i_x;
        case (i_op)
            OP_AND:    o_y = i_x & i_z;
            OP_OR:     o_y = i_x | i_z;
            OP_XOR:    o_y = i_x ^ i_z;
            OP_NAND:   o_y = ~(i_x & i_z);
            OP_NOR:    o_y = ~(i_x | i_z);
            OP_XNOR:   o_y = ~(i_x ^ i_z);
            OP_ANDNOT: o_y = i_x & ~i_z;
            OP_PASS_A: o_y = i_x;
            default:   o_y = i_x;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe
// Description : Registered bitwise logic unit with valid/ready handshake and
//               chained accumulate bursts. Single beats produce y=f(op,a,b)
//               with one cycle latency; a burst folds each subsequent a into
//               the running result with the opcode latched on its first beat.
// Ports       : clk, rst (sync, active-high)
//               in_valid/in_ready, a, b, op, acc_mode, last  - input beat
//               out_valid/out_ready, y, beats                - result
//               y_par (only with LOGIC_UNIT_PARITY_EN)       - ^y
// Config      : `define LOGIC_UNIT_PARITY_EN adds the y_par output.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] beats
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             y_par
`endif
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e             r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_y;
    logic [CNT_W-1:0]   r_beats;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    op_e                r_burst_op;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    state_e             w_state_nxt;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_take;
    logic [WIDTH-1:0]   w_f_ab;
    logic [WIDTH-1:0]   w_f_acc;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_load_out;
    logic [WIDTH-1:0]   w_out_data;
    logic [CNT_W-1:0]   w_out_beats;
    logic               w_acc_start;
    logic               w_acc_step;

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_take     = r_out_valid && out_ready;

    // Beat counter saturates instead of wrapping
    assign w_cnt_inc  = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_CNT_ONE;

    // Fresh operands path
    logic_op #(.WIDTH(WIDTH)) u_op_ab (
        .i_op (op_e'(op)),
        .i_x  (a),
        .i_z  (b),
        .o_y  (w_f_ab)
    );

    // Accumulator fold path: running result with the new a, using the
    // opcode captured at the start of the burst
    logic_op #(.WIDTH(WIDTH)) u_op_acc (
        .i_op (r_burst_op),
        .i_x  (r_acc),
        .i_z  (a),
        .o_y  (w_f_acc)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_out_data  = w_f_ab;
        w_out_beats = C_CNT_ONE;
        w_acc_start = 1'b0;
        w_acc_step  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (acc_mode && !last) begin
                        w_acc_start = 1'b1;
                        w_state_nxt = ACC;
                    end else begin
                        // Plain beat, or a one-beat burst
                        w_load_out  = 1'b1;
                        w_out_data  = w_f_ab;
                        w_out_beats = C_CNT_ONE;
                    end
                end
            end
            ACC: begin
                if (w_accept) begin
                    // Dropping acc_mode ends the burst just like last
                    if (last || !acc_mode) begin
                        w_load_out  = 1'b1;
                        w_out_data  = w_f_acc;
                        w_out_beats = w_cnt_inc;
                        w_state_nxt = IDLE;
                    end else begin
                        w_acc_step  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Burst accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_burst_op <= OP_AND;
        end else if (w_acc_start) begin
            r_acc      <= w_f_ab;
            r_cnt      <= C_CNT_ONE;
            r_burst_op <= op_e'(op);
        end else if (w_acc_step) begin
            r_acc      <= w_f_acc;
            r_cnt      <= w_cnt_inc;
        end
    end

    // ------------------------------------------------------------------
    // Output register. A load only happens on an accepted beat, which
    // requires in_ready, so a stalled result can never be overwritten.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_beats     <= '0;
        end else if (w_load_out) begin
            r_out_valid <= 1'b1;
            r_y         <= w_out_data;
            r_beats     <= w_out_beats;
        end else if (w_take) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    logic r_y_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_par <= 1'b0;
        end else if (w_load_out) begin
            r_y_par <= ^w_out_data;
        end
    end

    assign y_par = r_y_par;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign beats     = r_beats;

endmodule
`default_nettype wire

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning operand/result width in bits (1..64).
REQ-002 SHALL provide parameter CNT_W, default 4, meaning width of the beat counter.
REQ-003 SHALL have port clk input 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst input 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid input 1: an operand beat is presented.
REQ-006 SHALL have port in_ready output 1: the block accepts the beat this cycle.
REQ-007 SHALL have port a input WIDTH: first operand.
REQ-008 SHALL have port b input WIDTH: second operand.
REQ-009 SHALL have port op input 3: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDNOT (a&~b), 7 PASS_A.
REQ-010 SHALL have port acc_mode input 1: the beat belongs to a chained accumulate burst.
REQ-011 SHALL have port last input 1: final beat of a burst; ignored when acc_mode=0.
REQ-012 SHALL have port out_valid output 1: a result is held in y.
REQ-013 SHALL have port out_ready input 1: the consumer takes the result.
REQ-014 SHALL have port y output WIDTH: registered result.
REQ-015 SHALL have port beats output CNT_W: number of beats folded into y, saturating.

Function
REQ-016 SHALL define a beat as accepted when in_valid && in_ready are high on a rising edge, and the result as taken when out_valid && out_ready are high.
REQ-017 SHALL drive in_ready = !out_valid || out_ready, combinationally, in every state.
REQ-018 SHALL use the FSM states IDLE and ACC; the output register holds valid data independently of the state.
REQ-019 SHALL, in IDLE, load y=f(op,a,b), beats=1 and out_valid=1 on the next edge when it accepts a beat with acc_mode=0, giving 1-cycle latency.
REQ-020 SHALL, in IDLE, load acc=f(op,a,b), latch op as burst_op, set cnt=1 and go to ACC when it accepts a beat with acc_mode=1 and last=0.
REQ-021 SHALL treat an accepted IDLE beat with acc_mode=1 and last=1 as a single beat (REQ-019).
REQ-022 SHALL, in ACC, update acc=f(burst_op,acc,a) on each accepted beat, ignore b and the op input, and increment cnt.
REQ-023 SHALL, on the accepted ACC beat with last=1, load y=f(burst_op,acc,a), beats=cnt+1 and out_valid=1, and return to IDLE.
REQ-024 SHALL hold beats at 2^CNT_W-1 once that value is reached, with no wrap-around, while accumulation continues.
REQ-025 SHALL, in ACC, treat an accepted beat with acc_mode=0 as the terminating beat (same as last=1).
REQ-026 SHALL clear out_valid after a take with no new result on the same edge; a take and a new result on the same edge SHALL reload y with no bubble.
REQ-027 SHALL keep y and beats stable while out_valid=1 and out_ready=0.

Reset
REQ-028 SHALL, on rst, set state=IDLE, out_valid=0, y=0, beats=0, acc=0, cnt=0 and burst_op=0 on the next edge.
REQ-029 SHALL, on rst mid-burst or with a result pending, discard the partial accumulator and the pending result, with no output emitted.
REQ-030 SHALL give rst priority over a simultaneous handshake.

Configuration
REQ-031 SHALL, with LOGIC_UNIT_PARITY_EN defined, add output y_par (1 bit) registered with y, equal to ^y, and reset to 0.
REQ-032 SHALL, without LOGIC_UNIT_PARITY_EN, omit the y_par port and its logic entirely.

Structure
REQ-033 SHALL place the op encoding enum (3-bit), the FSM state typedef and the opcode constants in the shared package logic_unit_pkg.
REQ-034 SHALL implement f(op,x,z) as the combinational sub-module logic_op (parameter WIDTH), instantiated once for the (a,b) path and once for the (acc,a) path.

Verification
REQ-035 SHALL verify: WIDTH=8, op=AND, a=8'hF0, b=8'h3C, acc_mode=0 -> next cycle y=8'h30, beats=1, out_valid=1.
REQ-036 SHALL verify: all 8 ops with a=8'hA5, b=8'h0F -> y=05,AF,AA,FA,50,55,A0,A5.
REQ-037 SHALL verify: acc burst op=XOR, (a,b)=(01,02), then a=04, then a=08 with last=1 -> y=8'h0F, beats=3.
REQ-038 SHALL verify: out_ready=0 for 5 cycles with a result held -> in_ready=0, y stable; then out_ready=1 with in_valid=1 -> back-to-back results, no bubble.
REQ-039 SHALL verify: CNT_W=2, 6-beat op=OR burst -> beats=3 (saturated), y equals the OR of the 6 beats.
REQ-040 SHALL verify: rst asserted after 2 beats of a burst -> out_valid=0, state IDLE; a following single AND beat returns the correct result with beats=1.
